secded_decode_engine: RTL and testbench
=======================================

// Module: secded_decode_engine
// PURPOSE
//  Program-2 stage, directly downstream of the program-1 Hamming encoder.
//  On start, reads NUM_MSGS 16-bit SECDED codewords from data memory
//  (lo byte at even address, hi byte at odd) and corrects single-bit errors.
//  Writes each recovered 11-bit message plus F1/F0 error flags back to memory.
//  Single memory port; the block is the sole master while busy.
// PARAMETERS
//  SRC_BASE  30  byte address of first codeword (lo byte)
//  DST_BASE  0   byte address of first decoded message (lo byte)
//  NUM_MSGS  15  codewords per run, 1..127
//  ADDR_W    8   memory address width
// PORTS
//  clk          in   1       single clock; all state on posedge
//  reset        in   1       synchronous, active-high
//  start        in   1       1-cycle launch pulse; ignored unless IDLE or DONE
//  done         out  1       high in DONE; held until next accepted start/reset
//  mem_addr     out  ADDR_W  byte address; read data is combinational (same cycle)
//  mem_rd_data  in   8       read data for mem_addr
//  mem_wr_en    out  1       write strobe; memory captures at posedge
//  mem_wr_data  out  8       write data
// BEHAVIOUR
//  Reset: state=IDLE, i=0, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
//  Codeword bit k = Hamming position k:
//    {d11..d5,p8,d4,d3,d2,p4,d1,p2,p1,p0}, bits [15:0].
//  Decode:
//    syndrome s[3:0] = XOR of indices k (1..15) with cw[k]=1; P = ^cw[15:0].
//    P=0, s=0  -> clean: F1=0, F0=0.
//    P=1       -> single error: flip cw[s] (s=0 means p0), F0=1.
//    P=0, s!=0 -> double error: no correction, F1=1, data taken raw.
//  Output: hi={F1,F0,3'b000,d11,d10,d9} -> DST_BASE+2i+1;
//          lo={d8..d1} -> DST_BASE+2i.
//  FSM (5 cycles/message, i = message index):
//    IDLE:   start -> RD_LO, i=0.
//    RD_LO:  addr=SRC_BASE+2i, latch lo -> RD_HI.
//    RD_HI:  addr=SRC_BASE+2i+1, latch hi -> DECODE.
//    DECODE: register s, P, corrected data, flags -> WR_LO.
//    WR_LO:  wr_en=1, addr=DST_BASE+2i -> WR_HI.
//    WR_HI:  wr_en=1, addr=DST_BASE+2i+1;
//            i==NUM_MSGS-1 -> DONE, else i++ -> RD_LO.
//    DONE:   done=1; start -> RD_LO (done drops next cycle, i=0).
//  Timing:
//    - start sampled at edge T: done first high at T+5*NUM_MSGS.
//    - mem_wr_en high only in WR_LO/WR_HI: exactly 2*NUM_MSGS writes per run.
//  Boundary conditions:
//    - start while busy: ignored, no restart.
//    - reset mid-run: IDLE next edge, no further writes; partial output stays.
//    - Address arithmetic is modulo 2^ADDR_W (wraps silently).
//    - SRC/DST overlap is undefined.
// CONFIGURATION
//  SECDED_STATS_EN defined:
//    - adds outputs err1_cnt[6:0] and err2_cnt[6:0].
//    - counters clear on reset and on accepted start.
//    - they increment in DECODE on F0 / F1 respectively; held in DONE.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  T1 cw 16'hFFFF (d=11'h7FF clean) -> hi 8'h07, lo 8'hFF.
//  T2 cw 16'h0020 (bit5 flipped on zero msg) -> hi 8'h40, lo 8'h00 (corrected).
//  T3 cw 16'hFFFE (p0 flipped, s=0, P=1) -> hi 8'h47, lo 8'hFF.
//  T4 cw 16'h0003 (bits 0,1; s=1, P=0) -> hi 8'h80, lo 8'h00 (F1, no fix).
//  T5 15 random codewords run -> 30 writes, done exactly 75 cycles after start;
//     start pulse mid-run ignored.
//  T6 reset asserted in WR_LO of msg 3 -> no write that cycle, done=0, IDLE;
//     restart completes normally; STATS_EN counts match injected errors.

Source files
------------

// File: rtl/secded_decode_engine_if.sv
// Memory-port and start/done bundle for the SECDED decode engine.
// master = engine side, slave = memory / controller side.
interface secded_decode_engine_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;

  modport master (
    input  start,
    input  mem_rd_data,
    output done,
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data
  );

  modport slave (
    output start,
    output mem_rd_data,
    input  done,
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data
  );
endinterface

// File: rtl/secded_decode_engine.sv
// SECDED(16,11) decoder: reads codewords, fixes single errors, writes back.
// Optional SECDED_STATS_EN adds err1_cnt / err2_cnt error counters.
module secded_decode_engine #(
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int NUM_MSGS = 15,
  parameter int ADDR_W   = 8
) (
  input  logic clk,
  input  logic reset,
  secded_decode_engine_if.master bus
`ifdef SECDED_STATS_EN
  ,
  output logic [6:0] err1_cnt,
  output logic [6:0] err2_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] SRC  = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST  = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO  = ADDR_W'(2);
  localparam logic [6:0]        LAST = 7'(NUM_MSGS - 1);

  state_t            state;
  logic [6:0]        i;
  logic              done_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        lo_q;
  logic [7:0]        hi_q;
  logic [7:0]        hi_out;

  logic [ADDR_W-1:0] i2;
  logic [15:0]       cw;
  logic [3:0]        syn;
  logic              par;
  logic              f0;
  logic              f1;
  logic [7:0]        lo_b;
  logic [7:0]        hi_b;

  function automatic logic fb(
    input logic [15:0] c,
    input logic [3:0]  sy,
    input logic        pp,
    input int          k
  );
    return c[k] ^ (pp && (sy == 4'(k)));
  endfunction

  assign i2 = ADDR_W'({i, 1'b0});
  assign cw = {hi_q, lo_q};

  always_comb begin
    syn = '0;
    for (int k = 1; k < 16; k++)
      if (cw[k]) syn = syn ^ 4'(k);
    par  = ^cw;
    f0   = par;
    f1   = ~par & (syn != 4'd0);
    lo_b = {fb(cw, syn, par, 12), fb(cw, syn, par, 11),
            fb(cw, syn, par, 10), fb(cw, syn, par, 9),
            fb(cw, syn, par, 7),  fb(cw, syn, par, 6),
            fb(cw, syn, par, 5),  fb(cw, syn, par, 3)};
    hi_b = {f1, f0, 3'b000,
            fb(cw, syn, par, 15), fb(cw, syn, par, 14),
            fb(cw, syn, par, 13)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      hi_out    <= '0;
`ifdef SECDED_STATS_EN
      err1_cnt  <= '0;
      err2_cnt  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= RD_LO;
            i      <= '0;
            done_q <= 1'b0;
            addr_q <= SRC;
`ifdef SECDED_STATS_EN
            err1_cnt <= '0;
            err2_cnt <= '0;
`endif
          end
        end
        RD_LO: begin
          lo_q   <= bus.mem_rd_data;
          addr_q <= SRC + i2 + ONE;
          state  <= RD_HI;
        end
        RD_HI: begin
          hi_q  <= bus.mem_rd_data;
          state <= DECODE;
        end
        DECODE: begin
          addr_q    <= DST + i2;
          wr_en_q   <= 1'b1;
          wr_data_q <= lo_b;
          hi_out    <= hi_b;
`ifdef SECDED_STATS_EN
          err1_cnt  <= err1_cnt + {6'b0, f0};
          err2_cnt  <= err2_cnt + {6'b0, f1};
`endif
          state     <= WR_LO;
        end
        WR_LO: begin
          addr_q    <= DST + i2 + ONE;
          wr_data_q <= hi_out;
          state     <= WR_HI;
        end
        WR_HI: begin
          wr_en_q <= 1'b0;
          if (i == LAST) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            i      <= i + 7'd1;
            addr_q <= SRC + i2 + TWO;
            state  <= RD_LO;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset masks the strobe so a write in flight is not captured.
  assign bus.mem_wr_en   = wr_en_q & ~reset;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = wr_data_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_secded_decode_engine.sv
// Directed bench for secded_decode_engine: byte memory model,
// hand vectors plus encoded messages with injected errors.
module tb_secded_decode_engine;

  logic clk;
  logic reset;
  logic clr;
  int   checks;
  int   fails;
  int   wcount;
  int   oob;
  int   n1;
  int   n2;

  logic [7:0] src [64];
  logic [7:0] dst [32];
  logic [7:0] ehi [15];
  logic [7:0] elo [15];

  secded_decode_engine_if #(.ADDR_W(8)) bus ();

`ifdef SECDED_STATS_EN
  logic [6:0] err1_cnt;
  logic [6:0] err2_cnt;
`endif

  secded_decode_engine #(
    .SRC_BASE(30),
    .DST_BASE(0),
    .NUM_MSGS(15),
    .ADDR_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
`ifdef SECDED_STATS_EN
    ,
    .err1_cnt(err1_cnt),
    .err2_cnt(err2_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.mem_rd_data = (bus.mem_addr < 8'd64) ?
                           src[bus.mem_addr[5:0]] : 8'h00;

  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 32; k++) dst[k] <= 8'hA5;
      wcount <= 0;
      oob    <= 0;
    end else if (bus.mem_wr_en) begin
      if (bus.mem_addr < 8'd32) dst[bus.mem_addr[4:0]] <= bus.mem_wr_data;
      else oob <= oob + 1;
      wcount <= wcount + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] c;
    int j;
    c = '0;
    j = 0;
    for (int k = 3; k < 16; k++)
      if (k != 4 && k != 8) begin
        c[k] = d[j];
        j++;
      end
    for (int p = 1; p < 16; p = p * 2)
      for (int k = 1; k < 16; k++)
        if ((k & p) != 0 && k != p) c[p] = c[p] ^ c[k];
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] ext(input logic [15:0] c);
    logic [10:0] d;
    int j;
    d = '0;
    j = 0;
    for (int k = 3; k < 16; k++)
      if (k != 4 && k != 8) begin
        d[j] = c[k];
        j++;
      end
    return d;
  endfunction

  task automatic build_set(input bit directed);
    logic [15:0] dcw [4] = '{16'hFFFF, 16'h0020, 16'hFFFE, 16'h0003};
    logic [7:0]  dhi [4] = '{8'h07, 8'h40, 8'h47, 8'h80};
    logic [7:0]  dlo [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    logic [10:0] d;
    logic [10:0] raw;
    logic [15:0] c;
    int e;
    int a;
    int b;
    n1 = 0;
    n2 = 0;
    for (int m = 0; m < 15; m++) begin
      if (directed && m < 4) begin
        c      = dcw[m];
        ehi[m] = dhi[m];
        elo[m] = dlo[m];
        if (m == 1 || m == 2) n1++;
        if (m == 3) n2++;
      end else begin
        d = 11'($urandom_range(0, 2047));
        c = enc(d);
        e = $urandom_range(0, 2);
        if (e == 0) begin
          ehi[m] = {5'b00000, d[10:8]};
          elo[m] = d[7:0];
        end else if (e == 1) begin
          a = $urandom_range(0, 15);
          c[a] = ~c[a];
          ehi[m] = {5'b01000, d[10:8]};
          elo[m] = d[7:0];
          n1++;
        end else begin
          a = $urandom_range(0, 15);
          b = (a + $urandom_range(1, 15)) % 16;
          c[a] = ~c[a];
          c[b] = ~c[b];
          raw = ext(c);
          ehi[m] = {5'b10000, raw[10:8]};
          elo[m] = raw[7:0];
          n2++;
        end
      end
      src[30 + 2 * m] = c[7:0];
      src[31 + 2 * m] = c[15:8];
    end
  endtask

  task automatic clear_dst();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic check_msgs(input string tag, input int cnt);
    for (int m = 0; m < cnt; m++) begin
      chk($sformatf("%s_lo%0d", tag, m), {24'b0, dst[2 * m]}, {24'b0, elo[m]});
      chk($sformatf("%s_hi%0d", tag, m), {24'b0, dst[2 * m + 1]}, {24'b0, ehi[m]});
    end
  endtask

  task automatic run_full(input string tag);
    int cyc;
    int first;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_done_low"}, {31'b0, bus.done}, 32'd0);
    first = -1;
    cyc = 0;
    while (first < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == 20);
      if (bus.done) first = cyc;
    end
    bus.start = 1'b0;
    chk({tag, "_done_lat"}, first, 32'd75);
    chk({tag, "_writes"}, wcount, 32'd30);
    chk({tag, "_oob"}, oob, 32'd0);
    check_msgs(tag, 15);
`ifdef SECDED_STATS_EN
    chk({tag, "_err1"}, {25'b0, err1_cnt}, n1);
    chk({tag, "_err2"}, {25'b0, err2_cnt}, n2);
`endif
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    reset     = 1'b1;
    clr       = 1'b0;
    bus.start = 1'b0;
    for (int k = 0; k < 64; k++) src[k] = 8'h00;
    clear_dst();
    repeat (2) @(negedge clk);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_wren", {31'b0, bus.mem_wr_en}, 32'd0);
    chk("rst_addr", {24'b0, bus.mem_addr}, 32'd0);
    chk("rst_wdata", {24'b0, bus.mem_wr_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Run 1: directed T1..T4 then encoded messages, launched from IDLE.
    build_set(1'b1);
    clear_dst();
    run_full("run1");

    // Run 2: launched from DONE, reset during WR_LO of message 3.
    build_set(1'b0);
    clear_dst();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("run2_done_drop", {31'b0, bus.done}, 32'd0);
    for (int c = 1; c <= 18; c++) @(negedge clk);
    chk("run2_wrlo_en", {31'b0, bus.mem_wr_en}, 32'd1);
    chk("run2_wrlo_addr", {24'b0, bus.mem_addr}, 32'd6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_done", {31'b0, bus.done}, 32'd0);
    chk("rst_mid_wren", {31'b0, bus.mem_wr_en}, 32'd0);
    chk("rst_mid_addr", {24'b0, bus.mem_addr}, 32'd0);
`ifdef SECDED_STATS_EN
    chk("rst_mid_err1", {25'b0, err1_cnt}, 32'd0);
    chk("rst_mid_err2", {25'b0, err2_cnt}, 32'd0);
`endif
    repeat (10) @(negedge clk);
    chk("rst_mid_writes", wcount, 32'd6);
    chk("rst_mid_done2", {31'b0, bus.done}, 32'd0);
    check_msgs("part", 3);
    chk("part_lo3", {24'b0, dst[6]}, 32'hA5);
    chk("part_hi3", {24'b0, dst[7]}, 32'hA5);

    // Run 3: clean restart from IDLE on the same source data.
    clear_dst();
    run_full("run3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
